ngc_counter_sequencer: RTL and testbench

Segment-sequencing controller for the `ngc` up/down counter. It holds a small table of count segments, each with from, to, step and direction. On `start` it loads each segment into the counter in order, runs the counter until it reports a hit, then advances to the next segment. After the last segment it either stops with a `done` pulse or loops back to segment 0. It sits between a CPU/config master and one counter instance, and drives every counter control input.

---
 rtl/ngc_counter_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_ngc_counter_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ngc_counter_sequencer.sv
// ngc_counter_sequencer
// Walks a small table of count segments (from, to, step, direction) through a
// single ngc up/down counter. Each segment is loaded, run until the counter
// reports a hit, then the next one follows. After the last segment the
// sequence either stops with a done pulse or wraps back to segment 0.
//
// Handshake: start is a request taken only on an edge where the FSM is idle
// (busy low). busy rises in the following cycle and stays high until the
// cycle in which done pulses, or until the cycle after the CLEAR cycle that
// an abort produces. start and cfg_we are ignored while busy is high.
module ngc_counter_sequencer #(
    parameter int COUNT_WIDTH = 8,
    parameter int NUM_SEGS    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_SEGS)-1:0]   cfg_addr,
    input  logic [COUNT_WIDTH-1:0]        cfg_from,
    input  logic [COUNT_WIDTH-1:0]        cfg_to,
    input  logic [COUNT_WIDTH/2-1:0]      cfg_step,
    input  logic                          cfg_dir,
    input  logic [$clog2(NUM_SEGS)-1:0]   cfg_last,
    input  logic                          cfg_loop,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          seg_hit,
    output logic [$clog2(NUM_SEGS)-1:0]   seg_idx,
    output logic                          cnt_rst,
    output logic                          cnt_load,
    output logic                          cnt_enb,
    output logic                          cnt_dir,
    output logic                          cnt_one_shot,
    output logic [COUNT_WIDTH-1:0]        cnt_load_value,
    output logic [COUNT_WIDTH-1:0]        cnt_count_from_value,
    output logic [COUNT_WIDTH-1:0]        cnt_count_to_value,
    output logic [COUNT_WIDTH/2-1:0]      cnt_step_value,
    input  logic [COUNT_WIDTH-1:0]        cnt_count,
    input  logic                          cnt_count_hit
);

    localparam int AW = $clog2(NUM_SEGS);
    localparam int SW = COUNT_WIDTH / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    // The counter value is for monitoring only; nothing in here depends on it.
    logic cnt_count_unused;
    assign cnt_count_unused = ^cnt_count;

    // ---------------------------------------------------------------------
    // Segment table (flops)
    // ---------------------------------------------------------------------
    logic [COUNT_WIDTH-1:0] from_q [NUM_SEGS];
    logic [COUNT_WIDTH-1:0] from_d [NUM_SEGS];
    logic [COUNT_WIDTH-1:0] to_q   [NUM_SEGS];
    logic [COUNT_WIDTH-1:0] to_d   [NUM_SEGS];
    logic [SW-1:0]          step_q [NUM_SEGS];
    logic [SW-1:0]          step_d [NUM_SEGS];
    logic                   dir_q  [NUM_SEGS];
    logic                   dir_d  [NUM_SEGS];

    state_t         state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [AW-1:0]  last_q, last_d;
    logic           loop_q, loop_d;
    logic           guard_q, guard_d;

    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   seg_hit_q, seg_hit_d;
    logic                   cnt_rst_q, cnt_rst_d;
    logic                   cnt_load_q, cnt_load_d;
    logic                   cnt_enb_q, cnt_enb_d;
    logic                   cnt_dir_q, cnt_dir_d;
    logic                   cnt_one_shot_q, cnt_one_shot_d;
    logic [COUNT_WIDTH-1:0] load_val_q, load_val_d;
    logic [COUNT_WIDTH-1:0] from_val_q, from_val_d;
    logic [COUNT_WIDTH-1:0] to_val_q, to_val_d;
    logic [SW-1:0]          step_val_q, step_val_d;

    // Table write: accepted only while idle; a zero step is stored as 1.
    always_comb begin
        from_d = from_q;
        to_d   = to_q;
        step_d = step_q;
        dir_d  = dir_q;
        if (cfg_we && (state_q == ST_IDLE)) begin
            from_d[cfg_addr] = cfg_from;
            to_d[cfg_addr]   = cfg_to;
            step_d[cfg_addr] = (cfg_step == '0) ? SW'(1) : cfg_step;
            dir_d[cfg_addr]  = cfg_dir;
        end
    end

    // Table storage, cleared to all-zero fields on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SEGS; i++) begin
                from_q[i] <= '0;
                to_q[i]   <= '0;
                step_q[i] <= '0;
                dir_q[i]  <= 1'b0;
            end
        end else begin
            from_q <= from_d;
            to_q   <= to_d;
            step_q <= step_d;
            dir_q  <= dir_d;
        end
    end

    // Next-state logic: abort wins over start and over a sampled hit; the
    // first RUN cycle ignores the hit flag in case it is left over.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        loop_d    = loop_q;
        guard_d   = guard_q;
        seg_hit_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    last_d  = cfg_last;
                    loop_d  = cfg_loop;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_RUN;
                    guard_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else if (guard_q) begin
                    guard_d = 1'b0;
                end else if (cnt_count_hit) begin
                    seg_hit_d = 1'b1;
                    if (idx_q != last_q) begin
                        idx_d   = idx_q + AW'(1);
                        state_d = ST_LOAD;
                    end else if (loop_q) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = abort ? ST_CLEAR : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop; operands
    // are captured on entry to LOAD and held through RUN and afterwards.
    always_comb begin
        busy_d         = (state_d != ST_IDLE);
        cnt_rst_d      = (state_d == ST_CLEAR);
        cnt_load_d     = (state_d == ST_LOAD);
        cnt_enb_d      = (state_d == ST_RUN);
        cnt_dir_d      = cnt_dir_q;
        cnt_one_shot_d = cnt_one_shot_q;
        load_val_d     = load_val_q;
        from_val_d     = from_val_q;
        to_val_d       = to_val_q;
        step_val_d     = step_val_q;
        if (state_d == ST_LOAD) begin
            load_val_d     = from_q[idx_d];
            from_val_d     = from_q[idx_d];
            to_val_d       = to_q[idx_d];
            // A freshly reset entry holds step 0; run it as step 1.
            step_val_d     = (step_q[idx_d] == '0) ? SW'(1) : step_q[idx_d];
            cnt_dir_d      = dir_q[idx_d];
            cnt_one_shot_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            last_q         <= '0;
            loop_q         <= 1'b0;
            guard_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            seg_hit_q      <= 1'b0;
            cnt_rst_q      <= 1'b0;
            cnt_load_q     <= 1'b0;
            cnt_enb_q      <= 1'b0;
            cnt_dir_q      <= 1'b0;
            cnt_one_shot_q <= 1'b0;
            load_val_q     <= '0;
            from_val_q     <= '0;
            to_val_q       <= '0;
            step_val_q     <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            last_q         <= last_d;
            loop_q         <= loop_d;
            guard_q        <= guard_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            seg_hit_q      <= seg_hit_d;
            cnt_rst_q      <= cnt_rst_d;
            cnt_load_q     <= cnt_load_d;
            cnt_enb_q      <= cnt_enb_d;
            cnt_dir_q      <= cnt_dir_d;
            cnt_one_shot_q <= cnt_one_shot_d;
            load_val_q     <= load_val_d;
            from_val_q     <= from_val_d;
            to_val_q       <= to_val_d;
            step_val_q     <= step_val_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign seg_hit              = seg_hit_q;
    assign seg_idx              = idx_q;
    assign cnt_rst              = cnt_rst_q;
    assign cnt_load             = cnt_load_q;
    assign cnt_enb              = cnt_enb_q;
    assign cnt_dir              = cnt_dir_q;
    assign cnt_one_shot         = cnt_one_shot_q;
    assign cnt_load_value       = load_val_q;
    assign cnt_count_from_value = from_val_q;
    assign cnt_count_to_value   = to_val_q;
    assign cnt_step_value       = step_val_q;

endmodule

// File: tb/tb_ngc_counter_sequencer.sv
// Bench for ngc_counter_sequencer: a behavioural counter closes the loop,
// expected segment loads are queued when a sequence is started and popped
// when the DUT raises cnt_load.
module tb_ngc_counter_sequencer;

    localparam int CW = 8;
    localparam int NS = 4;
    localparam int AW = 2;
    localparam int SW = 4;
    localparam int EW = AW + 3 * CW + SW + 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [CW-1:0] cfg_from = '0;
    logic [CW-1:0] cfg_to = '0;
    logic [SW-1:0] cfg_step = '0;
    logic          cfg_dir = 1'b0;
    logic [AW-1:0] cfg_last = '0;
    logic          cfg_loop = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, seg_hit;
    logic [AW-1:0] seg_idx;
    logic          cnt_rst, cnt_load, cnt_enb, cnt_dir, cnt_one_shot;
    logic [CW-1:0] cnt_load_value, cnt_count_from_value, cnt_count_to_value;
    logic [SW-1:0] cnt_step_value;
    logic [CW-1:0] cnt_count;
    logic          cnt_count_hit;

    ngc_counter_sequencer #(.COUNT_WIDTH(CW), .NUM_SEGS(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_from(cfg_from), .cfg_to(cfg_to),
        .cfg_step(cfg_step), .cfg_dir(cfg_dir), .cfg_last(cfg_last), .cfg_loop(cfg_loop),
        .start(start), .abort(abort),
        .busy(busy), .done(done), .seg_hit(seg_hit), .seg_idx(seg_idx),
        .cnt_rst(cnt_rst), .cnt_load(cnt_load), .cnt_enb(cnt_enb), .cnt_dir(cnt_dir),
        .cnt_one_shot(cnt_one_shot), .cnt_load_value(cnt_load_value),
        .cnt_count_from_value(cnt_count_from_value), .cnt_count_to_value(cnt_count_to_value),
        .cnt_step_value(cnt_step_value), .cnt_count(cnt_count), .cnt_count_hit(cnt_count_hit)
    );

    // ---------------- behavioural counter ----------------
    // Registered hit: set one cycle after the count equals the target while enabled.
    logic [CW-1:0] m_count;
    logic          m_hit;
    logic          use_model = 1'b1;
    logic          force_hit = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count <= '0;
            m_hit   <= 1'b0;
        end else if (cnt_rst) begin
            m_count <= '0;
            m_hit   <= 1'b0;
        end else if (cnt_load) begin
            m_count <= cnt_load_value;
            m_hit   <= 1'b0;
        end else if (cnt_enb) begin
            m_hit <= (m_count == cnt_count_to_value);
            if (!(cnt_one_shot && (m_count == cnt_count_to_value)))
                m_count <= cnt_dir ? m_count + CW'(cnt_step_value)
                                   : m_count - CW'(cnt_step_value);
        end
    end

    assign cnt_count     = m_count;
    assign cnt_count_hit = use_model ? m_hit : force_hit;

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];

    // Shadow of what the segment table should hold.
    logic [CW-1:0] sh_from [NS];
    logic [CW-1:0] sh_to   [NS];
    logic [SW-1:0] sh_step [NS];
    logic          sh_dir  [NS];

    int n_load = 0, n_hit = 0, n_done = 0, n_busy = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pop an expected load on every cnt_load cycle, count pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy)    n_busy++;
            if (seg_hit) n_hit++;
            if (done)    n_done++;
            if (cnt_load) begin
                n_load++;
                check("load_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0)
                    check("load_fields",
                          64'({seg_idx, cnt_load_value, cnt_count_from_value,
                               cnt_count_to_value, cnt_step_value, cnt_dir, cnt_one_shot}),
                          64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        n_load = 0; n_hit = 0; n_done = 0; n_busy = 0;
    endtask

    task automatic cfg_write(input int addr, input int f, input int t, input int s,
                             input bit d, input bit take_effect);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_from = CW'(f);
        cfg_to   = CW'(t);
        cfg_step = SW'(s);
        cfg_dir  = d;
        if (take_effect) begin
            sh_from[addr] = CW'(f);
            sh_to[addr]   = CW'(t);
            sh_step[addr] = (s == 0) ? SW'(1) : SW'(s);
            sh_dir[addr]  = d;
        end
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic push_load(input int i);
        exp_q.push_back({AW'(i), sh_from[i], sh_from[i], sh_to[i], sh_step[i], sh_dir[i], 1'b1});
    endtask

    task automatic start_seq(input int last, input bit lp);
        cfg_last = AW'(last);
        cfg_loop = lp;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < NS; i++) begin
            sh_from[i] = '0; sh_to[i] = '0; sh_step[i] = SW'(1); sh_dir[i] = 1'b0;
        end
        #23;
        check("reset_outputs",
              64'({busy, done, seg_hit, seg_idx, cnt_rst, cnt_load, cnt_enb, cnt_dir,
                   cnt_one_shot, cnt_load_value, cnt_count_from_value,
                   cnt_count_to_value, cnt_step_value}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single segment 0->5 step 1 up.
        cfg_write(0, 0, 5, 1, 1'b1, 1'b1);
        clear_counts();
        push_load(0);
        start_seq(0, 1'b0);
        check("s1_busy_t1", 64'(busy), 64'd1);
        check("s1_load_t1", 64'(cnt_load), 64'd1);
        check("s1_loadval_t1", 64'(cnt_load_value), 64'd0);
        tick();
        check("s1_enb_t2", 64'({cnt_enb, cnt_load}), 64'b10);
        wait_done("s1", 40);
        check("s1_done_cycle", 64'({busy, seg_hit, cnt_enb}), 64'b010);
        tick();
        check("s1_done_pulse", 64'(done), 64'd0);
        check("s1_counts", 64'({8'(n_hit), 8'(n_done), 8'(n_load)}), 64'h010101);
        check("s1_busy_cycles", 64'(n_busy), 64'd8);

        // Three segments, stop after the last.
        cfg_write(0, 0, 10, 2, 1'b1, 1'b1);
        cfg_write(1, 10, 4, 3, 1'b0, 1'b1);
        cfg_write(2, 4, 4, 1, 1'b1, 1'b1);
        clear_counts();
        for (int i = 0; i < 3; i++) push_load(i);
        start_seq(2, 1'b0);
        wait_done("s3", 80);
        check("s3_idx_at_done", 64'(seg_idx), 64'd2);
        tick();
        check("s3_counts", 64'({8'(n_hit), 8'(n_done), 8'(n_load)}), 64'h030103);
        check("s3_busy_cycles", 64'(n_busy), 64'd16);
        check("s3_queue_empty", 64'(exp_q.size()), 64'd0);

        // Same table looping; abort just after wrapping back to segment 0.
        clear_counts();
        for (int i = 0; i < 3; i++) push_load(i);
        push_load(0);
        start_seq(2, 1'b1);
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 80; i++) begin
                if (seg_hit && seg_idx == 0) begin
                    got = 1'b1;
                    break;
                end
                tick();
            end
            check("loop_wrap_seen", 64'(got), 64'd1);
        end
        check("loop_wrap_load", 64'({cnt_load, cnt_load_value}), 64'h100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("loop_abort_a1", 64'({cnt_rst, busy, cnt_enb, seg_hit}), 64'b1100);
        tick();
        check("loop_abort_a2", 64'({cnt_rst, busy}), 64'b00);
        check("loop_counts", 64'({8'(n_hit), 8'(n_done), 8'(n_load)}), 64'h030004);
        check("loop_queue_empty", 64'(exp_q.size()), 64'd0);

        // Zero step written to segment 1 runs as step 1.
        cfg_write(1, 10, 4, 0, 1'b0, 1'b1);
        clear_counts();
        push_load(0);
        push_load(1);
        start_seq(1, 1'b0);
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (cnt_load && seg_idx == 1) begin
                    got = 1'b1;
                    break;
                end
                tick();
            end
            check("zstep_load_seen", 64'(got), 64'd1);
        end
        check("zstep_value", 64'(cnt_step_value), 64'd1);
        wait_done("zstep", 60);
        tick();
        check("zstep_busy_cycles", 64'(n_busy), 64'd17);

        // start and abort together in IDLE: CLEAR then IDLE, no LOAD.
        clear_counts();
        cfg_last = '0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_clear", 64'({cnt_rst, busy, cnt_load}), 64'b110);
        tick();
        check("sa_idle", 64'({cnt_rst, busy, cnt_load}), 64'b000);
        tick();
        check("sa_no_load", 64'(n_load), 64'd0);

        // Config writes while busy are dropped; readback run uses the old table.
        clear_counts();
        push_load(0);
        start_seq(0, 1'b0);
        cfg_write(0, 99, 7, 5, 1'b0, 1'b0);
        cfg_write(1, 55, 66, 2, 1'b1, 1'b0);
        wait_done("we_busy", 40);
        tick();
        push_load(0);
        push_load(1);
        start_seq(1, 1'b0);
        wait_done("readback", 60);
        tick();
        check("readback_counts", 64'({8'(n_done), 8'(n_load)}), 64'h0203);
        check("readback_queue_empty", 64'(exp_q.size()), 64'd0);

        // Stale hit in the guard cycle is ignored; abort beats a real hit.
        clear_counts();
        use_model = 1'b0;
        push_load(0);
        start_seq(0, 1'b0);
        tick();
        force_hit = 1'b1;
        tick();
        check("guard_ignored", 64'({seg_hit, cnt_enb, busy}), 64'b011);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        force_hit = 1'b0;
        check("abort_vs_hit", 64'({seg_hit, done, cnt_rst}), 64'b001);
        tick();
        check("abort_vs_hit_idle", 64'(busy), 64'd0);
        check("abort_vs_hit_counts", 64'({8'(n_hit), 8'(n_done)}), 64'h0000);
        use_model = 1'b1;

        // Reset in the middle of a run.
        clear_counts();
        for (int i = 0; i < 3; i++) push_load(i);
        start_seq(2, 1'b0);
        tick();
        tick();
        check("mid_run_busy", 64'({busy, cnt_enb}), 64'b11);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({busy, done, seg_hit, seg_idx, cnt_rst, cnt_load, cnt_enb, cnt_dir,
                   cnt_one_shot, cnt_load_value, cnt_count_from_value,
                   cnt_count_to_value, cnt_step_value}), 64'd0);
        exp_q.delete();
        for (int i = 0; i < NS; i++) begin
            sh_from[i] = '0; sh_to[i] = '0; sh_step[i] = SW'(1); sh_dir[i] = 1'b0;
        end
        tick();
        rst_n = 1'b1;
        tick();
        clear_counts();
        push_load(0);
        start_seq(0, 1'b0);
        check("post_reset_step", 64'({cnt_load, cnt_step_value, cnt_dir}), 64'({1'b1, SW'(1), 1'b0}));
        wait_done("post_reset", 30);
        tick();
        check("post_reset_busy_cycles", 64'(n_busy), 64'd3);
        check("post_reset_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: a stuck run still ends with a visible failure.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
